// File: rtl/enigma_core_ctrl.sv
// enigma_core_ctrl: owns rotor configuration and positions, steps the rotors
// for each accepted letter, and walks it through six ROM lookups and the
// UKW-B reflector before returning the cipher letter on a valid/ready port.
module enigma_core_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [2:0] cfg_type_l,
  input  logic [2:0] cfg_type_m,
  input  logic [2:0] cfg_type_r,
  input  logic [4:0] cfg_ring_l,
  input  logic [4:0] cfg_ring_m,
  input  logic [4:0] cfg_ring_r,
  input  logic [4:0] cfg_pos_l,
  input  logic [4:0] cfg_pos_m,
  input  logic [4:0] cfg_pos_r,
  input  logic       key_valid,
  input  logic [4:0] key_in,
  output logic       key_ready,
  output logic       out_valid,
  output logic [4:0] out_letter,
  input  logic       out_ready,
  output logic       err,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic [8:0] rom_addr0,
  output logic [8:0] rom_addr1,
  output logic [8:0] rom_addr2,
  output logic [8:0] rom_addr3,
  output logic [8:0] rom_addr4,
  output logic [8:0] rom_addr5,
  input  logic [15:0] rom_dout0,
  input  logic [15:0] rom_dout1,
  input  logic [15:0] rom_dout2,
  input  logic [15:0] rom_dout3,
  input  logic [15:0] rom_dout4,
  input  logic [15:0] rom_dout5
);

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_F0, S_F1, S_F2, S_REFL, S_B0, S_B1, S_B2, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] type_l_q, type_m_q, type_r_q, type_l_d, type_m_d, type_r_d;
  logic [4:0] ring_l_q, ring_m_q, ring_r_q, ring_l_d, ring_m_d, ring_r_d;
  logic [4:0] pos_l_q, pos_m_q, pos_r_q, pos_l_d, pos_m_d, pos_r_d;
  logic [4:0] cur_q, cur_d;
  logic       key_ready_q, key_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] out_letter_q, out_letter_d;
  logic       err_q, err_d;

  logic [2:0] st_type;
  logic [4:0] st_pos, st_ring, st_idx, st_result;
  logic       st_dir;
  logic [15:0] st_dout;
  logic [8:0] st_addr;
  logic       cfg_legal, mid_at_notch, right_at_notch;

  // Upper ROM data bits carry nothing this block needs.
  logic unused_dout_hi;
  assign unused_dout_hi = ^{rom_dout0[15:5], rom_dout1[15:5], rom_dout2[15:5],
                            rom_dout3[15:5], rom_dout4[15:5], rom_dout5[15:5]};

  // Reduce a value below 78 into 0..25 with at most two subtractions.
  function automatic logic [4:0] mod26(input logic [6:0] v);
    logic [6:0] t;
    t = v;
    if (t >= 7'd26) t = t - 7'd26;
    if (t >= 7'd26) t = t - 7'd26;
    return t[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Turnover notch letter of each rotor type (Q, E, V, J, Z).
  function automatic logic [4:0] notch(input logic [2:0] t);
    case (t)
      3'd0:    return 5'd16;
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      default: return 5'd25;
    endcase
  endfunction

  // Fixed UKW-B reflector wiring.
  function automatic logic [4:0] ukw_b(input logic [4:0] c);
    case (c)
      5'd0:  return 5'd24;  5'd1:  return 5'd17;  5'd2:  return 5'd20;
      5'd3:  return 5'd7;   5'd4:  return 5'd16;  5'd5:  return 5'd18;
      5'd6:  return 5'd11;  5'd7:  return 5'd3;   5'd8:  return 5'd15;
      5'd9:  return 5'd23;  5'd10: return 5'd13;  5'd11: return 5'd6;
      5'd12: return 5'd14;  5'd13: return 5'd10;  5'd14: return 5'd12;
      5'd15: return 5'd8;   5'd16: return 5'd4;   5'd17: return 5'd1;
      5'd18: return 5'd5;   5'd19: return 5'd25;  5'd20: return 5'd2;
      5'd21: return 5'd22;  5'd22: return 5'd21;  5'd23: return 5'd9;
      5'd24: return 5'd0;   default: return 5'd19;
    endcase
  endfunction

  // Pick the rotor, direction and ROM port that the current stage works on.
  always_comb begin
    st_type = 3'd0;
    st_pos  = 5'd0;
    st_ring = 5'd0;
    st_dir  = 1'b0;
    st_dout = 16'd0;
    case (state_q)
      S_F0: begin st_type = type_r_q; st_pos = pos_r_q; st_ring = ring_r_q; st_dout = rom_dout0; end
      S_F1: begin st_type = type_m_q; st_pos = pos_m_q; st_ring = ring_m_q; st_dout = rom_dout1; end
      S_F2: begin st_type = type_l_q; st_pos = pos_l_q; st_ring = ring_l_q; st_dout = rom_dout2; end
      S_B0: begin st_type = type_l_q; st_pos = pos_l_q; st_ring = ring_l_q; st_dir = 1'b1; st_dout = rom_dout3; end
      S_B1: begin st_type = type_m_q; st_pos = pos_m_q; st_ring = ring_m_q; st_dir = 1'b1; st_dout = rom_dout4; end
      S_B2: begin st_type = type_r_q; st_pos = pos_r_q; st_ring = ring_r_q; st_dir = 1'b1; st_dout = rom_dout5; end
      default: ;
    endcase
    st_idx    = mod26({2'b00, cur_q} + {2'b00, st_pos} + 7'd26 - {2'b00, st_ring});
    st_addr   = {6'd0, st_type} * 9'd52 + (st_dir ? 9'd26 : 9'd0) + {4'd0, st_idx};
    st_result = mod26({2'b00, st_dout[4:0]} + 7'd26 - {2'b00, st_pos} + {2'b00, st_ring});
  end

  // Only the port that belongs to the active stage carries an address.
  always_comb begin
    rom_addr0 = (state_q == S_F0) ? st_addr : 9'd0;
    rom_addr1 = (state_q == S_F1) ? st_addr : 9'd0;
    rom_addr2 = (state_q == S_F2) ? st_addr : 9'd0;
    rom_addr3 = (state_q == S_B0) ? st_addr : 9'd0;
    rom_addr4 = (state_q == S_B1) ? st_addr : 9'd0;
    rom_addr5 = (state_q == S_B2) ? st_addr : 9'd0;
  end

  // Sequencing, config loading, rotor stepping and registered output values.
  always_comb begin
    state_d      = state_q;
    type_l_d     = type_l_q;  type_m_d = type_m_q;  type_r_d = type_r_q;
    ring_l_d     = ring_l_q;  ring_m_d = ring_m_q;  ring_r_d = ring_r_q;
    pos_l_d      = pos_l_q;   pos_m_d  = pos_m_q;   pos_r_d  = pos_r_q;
    cur_d        = cur_q;
    out_letter_d = out_letter_q;
    err_d        = 1'b0;
    cfg_legal    = (cfg_type_l <= 3'd4) && (cfg_type_m <= 3'd4) && (cfg_type_r <= 3'd4) &&
                   (cfg_ring_l <= 5'd25) && (cfg_ring_m <= 5'd25) && (cfg_ring_r <= 5'd25) &&
                   (cfg_pos_l <= 5'd25) && (cfg_pos_m <= 5'd25) && (cfg_pos_r <= 5'd25);
    mid_at_notch   = (pos_m_q == notch(type_m_q));
    right_at_notch = (pos_r_q == notch(type_r_q));
    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (cfg_legal) begin
            type_l_d = cfg_type_l;  type_m_d = cfg_type_m;  type_r_d = cfg_type_r;
            ring_l_d = cfg_ring_l;  ring_m_d = cfg_ring_m;  ring_r_d = cfg_ring_r;
            pos_l_d  = cfg_pos_l;   pos_m_d  = cfg_pos_m;   pos_r_d  = cfg_pos_r;
          end else begin
            err_d = 1'b1;
          end
        end else if (key_valid) begin
          if (key_in <= 5'd25) begin
            cur_d   = key_in;
            state_d = S_STEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STEP: begin
        pos_r_d = inc26(pos_r_q);
        if (mid_at_notch || right_at_notch) pos_m_d = inc26(pos_m_q);
        if (mid_at_notch) pos_l_d = inc26(pos_l_q);
        state_d = S_F0;
      end
      S_F0:   begin cur_d = st_result; state_d = S_F1; end
      S_F1:   begin cur_d = st_result; state_d = S_F2; end
      S_F2:   begin cur_d = st_result; state_d = S_REFL; end
      S_REFL: begin cur_d = ukw_b(cur_q); state_d = S_B0; end
      S_B0:   begin cur_d = st_result; state_d = S_B1; end
      S_B1:   begin cur_d = st_result; state_d = S_B2; end
      S_B2:   begin cur_d = st_result; out_letter_d = st_result; state_d = S_DONE; end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    key_ready_d = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset drops any letter in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      type_l_q     <= 3'd0;  type_m_q <= 3'd0;  type_r_q <= 3'd0;
      ring_l_q     <= 5'd0;  ring_m_q <= 5'd0;  ring_r_q <= 5'd0;
      pos_l_q      <= 5'd0;  pos_m_q  <= 5'd0;  pos_r_q  <= 5'd0;
      cur_q        <= 5'd0;
      key_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      out_letter_q <= 5'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_l_q     <= type_l_d;  type_m_q <= type_m_d;  type_r_q <= type_r_d;
      ring_l_q     <= ring_l_d;  ring_m_q <= ring_m_d;  ring_r_q <= ring_r_d;
      pos_l_q      <= pos_l_d;   pos_m_q  <= pos_m_d;   pos_r_q  <= pos_r_d;
      cur_q        <= cur_d;
      key_ready_q  <= key_ready_d;
      out_valid_q  <= out_valid_d;
      out_letter_q <= out_letter_d;
      err_q        <= err_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign out_valid  = out_valid_q;
  assign out_letter = out_letter_q;
  assign err        = err_q;
  assign pos_l      = pos_l_q;
  assign pos_m      = pos_m_q;
  assign pos_r      = pos_r_q;

endmodule

// File: tb/tb_enigma_core_ctrl.sv
// Testbench for enigma_core_ctrl: provides the rotor ROM, keeps a
// letter-level Enigma model, and runs one task per feature.
module tb_enigma_core_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_type_l = '0, cfg_type_m = '0, cfg_type_r = '0;
  logic [4:0] cfg_ring_l = '0, cfg_ring_m = '0, cfg_ring_r = '0;
  logic [4:0] cfg_pos_l = '0, cfg_pos_m = '0, cfg_pos_r = '0;
  logic       key_valid = 1'b0;
  logic [4:0] key_in = '0;
  logic       key_ready, out_valid, err;
  logic [4:0] out_letter, pos_l, pos_m, pos_r;
  logic       out_ready = 1'b1;
  logic [8:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3, rom_addr4, rom_addr5;
  logic [15:0] rom_dout0, rom_dout1, rom_dout2, rom_dout3, rom_dout4, rom_dout5;
  logic [8:0] ra [6];

  int errors = 0;
  int checks = 0;
  int m_type [3];
  int m_ring [3];
  int m_pos  [3];

  always #5 clk = ~clk;

  enigma_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_type_l(cfg_type_l), .cfg_type_m(cfg_type_m), .cfg_type_r(cfg_type_r),
    .cfg_ring_l(cfg_ring_l), .cfg_ring_m(cfg_ring_m), .cfg_ring_r(cfg_ring_r),
    .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .out_valid(out_valid), .out_letter(out_letter), .out_ready(out_ready), .err(err),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .rom_addr0(rom_addr0), .rom_addr1(rom_addr1), .rom_addr2(rom_addr2),
    .rom_addr3(rom_addr3), .rom_addr4(rom_addr4), .rom_addr5(rom_addr5),
    .rom_dout0(rom_dout0), .rom_dout1(rom_dout1), .rom_dout2(rom_dout2),
    .rom_dout3(rom_dout3), .rom_dout4(rom_dout4), .rom_dout5(rom_dout5)
  );

  assign ra[0] = rom_addr0;  assign ra[1] = rom_addr1;  assign ra[2] = rom_addr2;
  assign ra[3] = rom_addr3;  assign ra[4] = rom_addr4;  assign ra[5] = rom_addr5;

  // Historical rotor wirings I..V, forward direction.
  function automatic int wire_f(int t, int i);
    string w;
    case (t)
      0: w = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
      1: w = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
      2: w = "BDFHJLCPRTXVZNYEIWGAKMQOUS";
      3: w = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
      default: w = "VZBRGITYUPSDNHLXAWMJQOFECK";
    endcase
    return int'(w[i]) - 65;
  endfunction

  function automatic int wire_b(int t, int i);
    for (int j = 0; j < 26; j++) if (wire_f(t, j) == i) return j;
    return 0;
  endfunction

  function automatic int reflect(int i);
    string w;
    w = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    return int'(w[i]) - 65;
  endfunction

  function automatic int notch_of(int t);
    string w;
    w = "QEVJZ";
    return int'(w[t]) - 65;
  endfunction

  // ROM contents with junk in the unused upper bits.
  function automatic logic [15:0] rom_fn(logic [8:0] a);
    int ai, t, d, i, v;
    ai = int'(a);
    t = ai / 52;
    d = (ai % 52) / 26;
    i = ai % 26;
    if (t > 4) return 16'h0;
    v = (d == 0) ? wire_f(t, i) : wire_b(t, i);
    return {11'h2A5, v[4:0]};
  endfunction

  assign rom_dout0 = rom_fn(rom_addr0);
  assign rom_dout1 = rom_fn(rom_addr1);
  assign rom_dout2 = rom_fn(rom_addr2);
  assign rom_dout3 = rom_fn(rom_addr3);
  assign rom_dout4 = rom_fn(rom_addr4);
  assign rom_dout5 = rom_fn(rom_addr5);

  // Letter-level model: rotor index 0 = left, 1 = middle, 2 = right.
  function automatic int through(int rot, int c, bit back);
    int idx, o;
    idx = (c + m_pos[rot] - m_ring[rot] + 26) % 26;
    o = back ? wire_b(m_type[rot], idx) : wire_f(m_type[rot], idx);
    return (o - m_pos[rot] + m_ring[rot] + 26) % 26;
  endfunction

  function automatic int menc(int k);
    int c;
    c = through(2, k, 0);
    c = through(1, c, 0);
    c = through(0, c, 0);
    c = reflect(c);
    c = through(0, c, 1);
    c = through(1, c, 1);
    return through(2, c, 1);
  endfunction

  task automatic mstep();
    bit mid, rt;
    mid = (m_pos[1] == notch_of(m_type[1]));
    rt  = (m_pos[2] == notch_of(m_type[2]));
    if (mid) m_pos[0] = (m_pos[0] + 1) % 26;
    if (mid || rt) m_pos[1] = (m_pos[1] + 1) % 26;
    m_pos[2] = (m_pos[2] + 1) % 26;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_type[i] = 0; m_ring[i] = 0; m_pos[i] = 0; end
  endtask

  task automatic do_reset();
    cfg_we = 0; key_valid = 0; out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // Pulse cfg_we for one cycle; model takes the config only when it is legal.
  task automatic apply_cfg(input int tl, tm, tr, rl, rm, rr, pl, pm, pr);
    cfg_type_l = 3'(tl); cfg_type_m = 3'(tm); cfg_type_r = 3'(tr);
    cfg_ring_l = 5'(rl); cfg_ring_m = 5'(rm); cfg_ring_r = 5'(rr);
    cfg_pos_l  = 5'(pl); cfg_pos_m  = 5'(pm); cfg_pos_r  = 5'(pr);
    cfg_we = 1;
    @(posedge clk); #1;
    cfg_we = 0;
    if (tl <= 4 && tm <= 4 && tr <= 4 && rl <= 25 && rm <= 25 && rr <= 25 &&
        pl <= 25 && pm <= 25 && pr <= 25) begin
      m_type[0] = tl; m_type[1] = tm; m_type[2] = tr;
      m_ring[0] = rl; m_ring[1] = rm; m_ring[2] = rr;
      m_pos[0]  = pl; m_pos[1]  = pm; m_pos[2]  = pr;
    end
  endtask

  // Offer a key and wait for the cipher letter; edges counted from acceptance.
  task automatic run_key(input int k, input bit complete,
                         output logic [4:0] letter, output int lat, output bit ok);
    int n;
    ok = 1; lat = 0; letter = '0; n = 0;
    while (key_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (key_ready !== 1'b1) begin ok = 0; return; end
    key_valid = 1; key_in = 5'(k);
    @(posedge clk); #1;
    key_valid = 0;
    while (out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (out_valid !== 1'b1) begin ok = 0; return; end
    letter = out_letter;
    if (complete) begin out_ready = 1; @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    checks++; if (out_valid !== 1'b0 || out_letter !== 5'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got=%b/%0d/%b exp=0/0/0", out_valid, out_letter, err); end
    checks++; if ({pos_l, pos_m, pos_r} !== 15'd0) begin
      errors++; $display("FAIL reset_pos got=%0d/%0d/%0d exp=0/0/0", pos_l, pos_m, pos_r); end
    for (int p = 0; p < 6; p++) begin
      checks++; if (ra[p] !== 9'd0) begin errors++; $display("FAIL reset_rom_addr%0d got=%0d exp=0", p, ra[p]); end
    end
  endtask

  task automatic test_basic();
    int exp_c [5] = '{1, 3, 25, 6, 14};
    logic [4:0] got; int lat; bit ok;
    $display("[TB] basic BDZGO sequence");
    apply_cfg(0, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      mstep();
      run_key(0, 1, got, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout key=%0d", i); end
      checks++; if (got !== 5'(exp_c[i]) || exp_c[i] != menc(0)) begin
        errors++; $display("FAIL basic_letter%0d got=%0d exp=%0d model=%0d", i, got, exp_c[i], menc(0)); end
    end
    checks++; if (pos_l !== 5'd0 || pos_m !== 5'd0 || pos_r !== 5'd5) begin
      errors++; $display("FAIL basic_pos got=%0d/%0d/%0d exp=0/0/5", pos_l, pos_m, pos_r); end
  endtask

  task automatic test_double_step();
    int exp_p [3][3] = '{'{0, 3, 21}, '{0, 4, 22}, '{1, 5, 23}};
    logic [4:0] got; int lat; bit ok; int k;
    $display("[TB] double step");
    apply_cfg(0, 1, 2, 0, 0, 0, 0, 3, 20);
    for (int i = 0; i < 3; i++) begin
      k = int'($urandom_range(0, 25));
      mstep();
      run_key(k, 1, got, lat, ok);
      checks++; if (!ok || got !== 5'(menc(k))) begin
        errors++; $display("FAIL dstep_letter%0d got=%0d exp=%0d ok=%0b", i, got, menc(k), ok); end
      checks++; if (pos_l !== 5'(exp_p[i][0]) || pos_m !== 5'(exp_p[i][1]) || pos_r !== 5'(exp_p[i][2]) ||
                    m_pos[2] != exp_p[i][2]) begin
        errors++; $display("FAIL dstep_pos%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, pos_l, pos_m, pos_r,
                           exp_p[i][0], exp_p[i][1], exp_p[i][2]); end
    end
  endtask

  // Latency and per-stage ROM port activity, checked every cycle.
  task automatic test_ports();
    int s_rot [6] = '{2, 1, 0, 0, 1, 2};
    int s_cyc [6] = '{1, 2, 3, 5, 6, 7};
    int ea [6][9];
    int c, idx, k;
    $display("[TB] ports and latency");
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin apply_cfg(0, 1, 2, 0, 0, 0, 0, 0, 0); k = 0; end
      else begin
        apply_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                  int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
        k = int'($urandom_range(0, 25));
      end
      mstep();
      for (int p = 0; p < 6; p++) for (int y = 0; y < 9; y++) ea[p][y] = 0;
      c = k;
      for (int s = 0; s < 6; s++) begin
        if (s == 3) c = reflect(c);
        idx = (c + m_pos[s_rot[s]] - m_ring[s_rot[s]] + 26) % 26;
        ea[s][s_cyc[s]] = m_type[s_rot[s]] * 52 + (s >= 3 ? 26 : 0) + idx;
        c = through(s_rot[s], c, s >= 3);
      end
      key_valid = 1; key_in = 5'(k);
      @(posedge clk); #1;
      key_valid = 0;
      for (int y = 0; y < 9; y++) begin
        if (y > 0) begin @(posedge clk); #1; end
        for (int p = 0; p < 6; p++) begin
          checks++; if (ra[p] !== 9'(ea[p][y])) begin
            errors++; $display("FAIL port_addr%0d_cyc%0d got=%0d exp=%0d", p, y, ra[p], ea[p][y]); end
        end
        checks++; if (out_valid !== (y == 8) || key_ready !== 1'b0) begin
          errors++; $display("FAIL latency_cyc%0d out_valid=%b key_ready=%b exp=%b/0", y, out_valid, key_ready, y == 8); end
        if (it == 0 && y == 1) begin
          checks++; if (rom_addr0 !== 9'd105) begin errors++; $display("FAIL port_f0_105 got=%0d exp=105", rom_addr0); end
        end
      end
      checks++; if (out_letter !== 5'(c)) begin errors++; $display("FAIL port_letter got=%0d exp=%0d", out_letter, c); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] got, exp_l; int lat; bit ok;
    $display("[TB] backpressure");
    out_ready = 0;
    mstep();
    exp_l = 5'(menc(7));
    run_key(7, 0, got, lat, ok);
    checks++; if (!ok || lat != 8) begin errors++; $display("FAIL bp_latency got=%0d exp=8 ok=%0b", lat, ok); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_letter !== exp_l || key_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%0d/%b exp=1/%0d/0", i, out_valid, out_letter, key_ready, exp_l); end
      key_valid = 1; key_in = 5'd3;
      @(posedge clk); #1;
    end
    key_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    checks++; if (key_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=%b/%b exp=1/0", key_ready, out_valid); end
  endtask

  task automatic test_errors();
    logic [4:0] got; int lat; bit ok; int seen;
    $display("[TB] error handling");
    apply_cfg(0, 1, 2, 0, 0, 0, 2, 3, 4);
    cfg_type_m = 3'd5; cfg_pos_l = 5'd9; cfg_pos_m = 5'd9; cfg_pos_r = 5'd9;
    cfg_we = 1;
    @(posedge clk); #1;
    cfg_we = 0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse got=%b exp=1", err); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cfg_err_width got=%b exp=0", err); end
    checks++; if (pos_l !== 5'd2 || pos_m !== 5'd3 || pos_r !== 5'd4) begin
      errors++; $display("FAIL cfg_retained got=%0d/%0d/%0d exp=2/3/4", pos_l, pos_m, pos_r); end
    key_valid = 1; key_in = 5'd27;
    @(posedge clk); #1;
    key_valid = 0;
    checks++; if (err !== 1'b1 || key_ready !== 1'b1) begin
      errors++; $display("FAIL key_err_pulse got=%b/%b exp=1/1", err, key_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid === 1'b1 || err === 1'b1) seen++; end
    checks++; if (seen != 0 || pos_l !== 5'd2 || pos_m !== 5'd3 || pos_r !== 5'd4) begin
      errors++; $display("FAIL key_err_effect got=%0d/%0d/%0d extra=%0d exp=2/3/4 extra=0", pos_l, pos_m, pos_r, seen); end
    cfg_type_l = 3'd3; cfg_type_m = 3'd4; cfg_type_r = 3'd0;
    cfg_ring_l = 5'd1; cfg_ring_m = 5'd2; cfg_ring_r = 5'd3;
    cfg_pos_l = 5'd5; cfg_pos_m = 5'd6; cfg_pos_r = 5'd7;
    cfg_we = 1; key_valid = 1; key_in = 5'd3;
    @(posedge clk); #1;
    cfg_we = 0; key_valid = 0;
    m_type = '{3, 4, 0}; m_ring = '{1, 2, 3}; m_pos = '{5, 6, 7};
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pos_l !== 5'd5 || pos_m !== 5'd6 || pos_r !== 5'd7 || key_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL cfg_wins got=%0d/%0d/%0d kr=%b ov=%b exp=5/6/7 1 0", pos_l, pos_m, pos_r, key_ready, out_valid); end
    mstep();
    run_key(11, 1, got, lat, ok);
    checks++; if (!ok || got !== 5'(menc(11))) begin errors++; $display("FAIL cfg_new_letter got=%0d exp=%0d", got, menc(11)); end
  endtask

  task automatic test_reset_midflight();
    logic [4:0] got; int lat; bit ok;
    $display("[TB] reset in flight");
    key_valid = 1; key_in = 5'd4;
    @(posedge clk); #1;
    key_valid = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++; if (key_ready !== 1'b1 || out_valid !== 1'b0 || out_letter !== 5'd0 || err !== 1'b0 ||
                  {pos_l, pos_m, pos_r} !== 15'd0) begin
      errors++; $display("FAIL midreset_outputs kr=%b ov=%b ol=%0d err=%b pos=%0d/%0d/%0d exp=1 0 0 0 0/0/0",
                         key_ready, out_valid, out_letter, err, pos_l, pos_m, pos_r); end
    checks++; if ({ra[0], ra[1], ra[2], ra[3], ra[4], ra[5]} !== 54'd0) begin
      errors++; $display("FAIL midreset_addr got=%0d exp=0", ra[2]); end
    @(negedge clk) rst_n = 1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_valid got=%b exp=0", out_valid); end
    mstep();
    run_key(0, 1, got, lat, ok);
    checks++; if (!ok || got !== 5'(menc(0)) || pos_r !== 5'd1) begin
      errors++; $display("FAIL midreset_encrypt got=%0d pos_r=%0d exp=%0d pos_r=1", got, pos_r, menc(0)); end
  endtask

  task automatic test_random();
    logic [4:0] got; int lat; bit ok; int k;
    $display("[TB] random configs");
    for (int r = 0; r < 4; r++) begin
      apply_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)),
                int'($urandom_range(0, 25)), int'($urandom_range(0, 25)), int'($urandom_range(0, 25)));
      for (int i = 0; i < 6; i++) begin
        k = int'($urandom_range(0, 25));
        mstep();
        run_key(k, 1, got, lat, ok);
        checks++; if (!ok || lat != 8 || got !== 5'(menc(k))) begin
          errors++; $display("FAIL random_letter got=%0d exp=%0d lat=%0d", got, menc(k), lat); end
        checks++; if (pos_l !== 5'(m_pos[0]) || pos_m !== 5'(m_pos[1]) || pos_r !== 5'(m_pos[2])) begin
          errors++; $display("FAIL random_pos got=%0d/%0d/%0d exp=%0d/%0d/%0d", pos_l, pos_m, pos_r,
                             m_pos[0], m_pos[1], m_pos[2]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_double_step();
    test_ports();
    test_backpressure();
    test_errors();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
